alu_arbiter: RTL and testbench

Shares the single combinational `ALU` between two requesters over valid/ready handshakes:
- port 0: integer execute stage.
- port 1: the branch/address-computation path.

The block arbitrates each cycle, drives the granted request's operands and control onto the ALU, and captures `Result`/`zero` into a per-port response register. It sits between the requesters and the `ALU` instance in the processor datapath.

---
 rtl/alu_arb_pkg.sv | 50 +++++
 rtl/alu_arb_rsp_slot.sv | 56 +++++
 rtl/alu_arbiter.sv | 169 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   ALU_DATA_W   - operand/result width of the shared ALU
//   ALU_OP_W     - width of the ALU Operation field
//   ALU_FLAG_W   - width of the ALU SetFlag field
//   alu_req_t    - one complete ALU request (operands plus controls)
//   ALU_IDLE_REQ - all-zero request driven onto the ALU when nobody is granted
//   alu_req_make - packs discrete request fields into an alu_req_t
package alu_arb_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_OP_W   = 2;
    localparam int ALU_FLAG_W = 3;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] in1;
        logic [ALU_DATA_W-1:0] in2;
        logic                  twoc;
        logic [ALU_OP_W-1:0]   op;
        logic [ALU_FLAG_W-1:0] setflag;
        logic                  lor;
        logic                  arith;
    } alu_req_t;

    localparam alu_req_t ALU_IDLE_REQ = '0;

    function automatic alu_req_t alu_req_make(
        input logic [ALU_DATA_W-1:0] in1,
        input logic [ALU_DATA_W-1:0] in2,
        input logic                  twoc,
        input logic [ALU_OP_W-1:0]   op,
        input logic [ALU_FLAG_W-1:0] setflag,
        input logic                  lor,
        input logic                  arith
    );
        alu_req_t req;
        req.in1     = in1;
        req.in2     = in2;
        req.twoc    = twoc;
        req.op      = op;
        req.setflag = setflag;
        req.lor     = lor;
        req.arith   = arith;
        return req;
    endfunction

endpackage

// File: rtl/alu_arb_rsp_slot.sv
// One-entry response slot holding an ALU result/zero pair for one requester.
// Latency: load at edge k -> o_rsp_valid high after edge k.
// Backpressure: o_slot_free low while holding an unconsumed result.
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   i_load          - capture i_result/i_zero this edge (request accepted)
//   i_result/i_zero - ALU outputs for the accepted request
//   i_rsp_ready     - consumer takes the held result this cycle
//   o_rsp_valid     - slot holds a result
//   o_result/o_zero - held result fields, stable while valid and not consumed
//   o_slot_free     - slot may be loaded this cycle (empty or draining)
module alu_arb_rsp_slot
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = ALU_DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_result,
    input  logic             i_zero,
    input  logic             i_rsp_ready,
    output logic             o_rsp_valid,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_slot_free
);

    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    // Draining slot counts as free so one port can sustain one op per cycle.
    assign o_slot_free = ~r_valid | i_rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else if (i_load) begin
            // A new load in the same cycle as a consume keeps the slot full.
            r_valid  <= 1'b1;
            r_result <= i_result;
            r_zero   <= i_zero;
        end else if (r_valid && i_rsp_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign o_rsp_valid = r_valid;
    assign o_result    = r_result;
    assign o_zero      = r_zero;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the execute stage (port 0) and the
// branch/address path (port 1). Latency: 1 cycle request-to-response.
// Backpressure: a port is only granted while its response slot is free.
//
// Ports:
//   clk, rst_n                       - clock, asynchronous active-low reset
//   pN_req_valid / pN_req_ready      - request handshake, port N
//   pN_in1, pN_in2, pN_twoc, pN_op,
//   pN_setflag, pN_lor, pN_arith     - request operands and ALU controls
//   pN_rsp_valid / pN_rsp_ready      - response handshake, port N
//   pN_result, pN_zero               - registered ALU result for port N
//   alu_in1 .. alu_arith             - to the shared ALU (all zero when idle)
//   alu_result, alu_zero             - from the shared ALU
//
// Build option: define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise port 0 has fixed priority.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = ALU_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic [WIDTH-1:0]      p0_in1,
    input  logic [WIDTH-1:0]      p0_in2,
    input  logic                  p0_twoc,
    input  logic [ALU_OP_W-1:0]   p0_op,
    input  logic [ALU_FLAG_W-1:0] p0_setflag,
    input  logic                  p0_lor,
    input  logic                  p0_arith,
    output logic                  p0_rsp_valid,
    input  logic                  p0_rsp_ready,
    output logic [WIDTH-1:0]      p0_result,
    output logic                  p0_zero,

    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic [WIDTH-1:0]      p1_in1,
    input  logic [WIDTH-1:0]      p1_in2,
    input  logic                  p1_twoc,
    input  logic [ALU_OP_W-1:0]   p1_op,
    input  logic [ALU_FLAG_W-1:0] p1_setflag,
    input  logic                  p1_lor,
    input  logic                  p1_arith,
    output logic                  p1_rsp_valid,
    input  logic                  p1_rsp_ready,
    output logic [WIDTH-1:0]      p1_result,
    output logic                  p1_zero,

    output logic [WIDTH-1:0]      alu_in1,
    output logic [WIDTH-1:0]      alu_in2,
    output logic                  alu_twoc,
    output logic [ALU_OP_W-1:0]   alu_op,
    output logic [ALU_FLAG_W-1:0] alu_setflag,
    output logic                  alu_lor,
    output logic                  alu_arith,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic                  alu_zero
);

    alu_req_t w_req0;
    alu_req_t w_req1;
    alu_req_t w_alu_req;
    logic     w_free0;
    logic     w_free1;
    logic     w_elig0;
    logic     w_elig1;
    logic     w_grant0;
    logic     w_grant1;
    logic     w_accept0;
    logic     w_accept1;

    assign w_req0 = alu_req_make(p0_in1, p0_in2, p0_twoc, p0_op,
                                 p0_setflag, p0_lor, p0_arith);
    assign w_req1 = alu_req_make(p1_in1, p1_in2, p1_twoc, p1_op,
                                 p1_setflag, p1_lor, p1_arith);

    // A port competes only if it has somewhere to put the result.
    assign w_elig0 = p0_req_valid & w_free0;
    assign w_elig1 = p1_req_valid & w_free1;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // Port that won the most recent accept; reset to 1 so port 0 goes first.
    logic r_last_grant;

    always_comb begin
        w_grant0 = w_elig0;
        w_grant1 = w_elig1;
        if (w_elig0 && w_elig1) begin
            w_grant0 = r_last_grant;
            w_grant1 = ~r_last_grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_accept0) begin
            r_last_grant <= 1'b0;
        end else if (w_accept1) begin
            r_last_grant <= 1'b1;
        end
    end
`else
    always_comb begin
        w_grant0 = w_elig0;
        w_grant1 = w_elig1 & ~w_elig0;
    end
`endif

    // Grants already imply a free slot; the extra term keeps the handshake
    // readable as "granted and has room".
    assign w_accept0    = w_grant0 & w_free0;
    assign w_accept1    = w_grant1 & w_free1;
    assign p0_req_ready = w_accept0;
    assign p1_req_ready = w_accept1;

    // Idle cycles drive all-zero onto the ALU so it sees no toggling inputs.
    always_comb begin
        w_alu_req = ALU_IDLE_REQ;
        if (w_grant0) begin
            w_alu_req = w_req0;
        end else if (w_grant1) begin
            w_alu_req = w_req1;
        end
    end

    assign alu_in1     = w_alu_req.in1;
    assign alu_in2     = w_alu_req.in2;
    assign alu_twoc    = w_alu_req.twoc;
    assign alu_op      = w_alu_req.op;
    assign alu_setflag = w_alu_req.setflag;
    assign alu_lor     = w_alu_req.lor;
    assign alu_arith   = w_alu_req.arith;

    alu_arb_rsp_slot #(
        .WIDTH (WIDTH)
    ) u_slot0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_accept0),
        .i_result    (alu_result),
        .i_zero      (alu_zero),
        .i_rsp_ready (p0_rsp_ready),
        .o_rsp_valid (p0_rsp_valid),
        .o_result    (p0_result),
        .o_zero      (p0_zero),
        .o_slot_free (w_free0)
    );

    alu_arb_rsp_slot #(
        .WIDTH (WIDTH)
    ) u_slot1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_accept1),
        .i_result    (alu_result),
        .i_zero      (alu_zero),
        .i_rsp_ready (p1_rsp_ready),
        .o_rsp_valid (p1_rsp_valid),
        .o_result    (p1_result),
        .o_zero      (p1_zero),
        .o_slot_free (w_free1)
    );

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU stand-in
// (op 00 add with optional two's-complement of in2, 01 and, 10 or, 11 shift).
// Inputs change 1 time unit after the rising edge; outputs are sampled 4 later.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        p0_req_valid, p0_req_ready, p0_twoc, p0_lor, p0_arith;
    logic        p0_rsp_valid, p0_rsp_ready, p0_zero;
    logic [31:0] p0_in1, p0_in2, p0_result;
    logic [1:0]  p0_op;
    logic [2:0]  p0_setflag;
    logic        p1_req_valid, p1_req_ready, p1_twoc, p1_lor, p1_arith;
    logic        p1_rsp_valid, p1_rsp_ready, p1_zero;
    logic [31:0] p1_in1, p1_in2, p1_result;
    logic [1:0]  p1_op;
    logic [2:0]  p1_setflag;
    logic [31:0] alu_in1, alu_in2, alu_result;
    logic        alu_twoc, alu_lor, alu_arith, alu_zero;
    logic [1:0]  alu_op;
    logic [2:0]  alu_setflag;

    int n_checks = 0;
    int n_pass   = 0;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
        .p0_in1(p0_in1), .p0_in2(p0_in2), .p0_twoc(p0_twoc), .p0_op(p0_op),
        .p0_setflag(p0_setflag), .p0_lor(p0_lor), .p0_arith(p0_arith),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready),
        .p0_result(p0_result), .p0_zero(p0_zero),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
        .p1_in1(p1_in1), .p1_in2(p1_in2), .p1_twoc(p1_twoc), .p1_op(p1_op),
        .p1_setflag(p1_setflag), .p1_lor(p1_lor), .p1_arith(p1_arith),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready),
        .p1_result(p1_result), .p1_zero(p1_zero),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_twoc(alu_twoc),
        .alu_op(alu_op), .alu_setflag(alu_setflag), .alu_lor(alu_lor),
        .alu_arith(alu_arith), .alu_result(alu_result), .alu_zero(alu_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural ALU stand-in.
    logic [31:0] alu_b;
    always_comb begin
        alu_b = alu_twoc ? (~alu_in2 + 32'd1) : alu_in2;
        case (alu_op)
            2'b00:   alu_result = alu_in1 + alu_b;
            2'b01:   alu_result = alu_in1 & alu_in2;
            2'b10:   alu_result = alu_in1 | alu_in2;
            default: begin
                if (alu_lor)        alu_result = alu_in1 << alu_in2[4:0];
                else if (alu_arith) alu_result = $unsigned($signed(alu_in1) >>> alu_in2[4:0]);
                else                alu_result = alu_in1 >> alu_in2[4:0];
            end
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic set_p0(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic tc);
        p0_req_valid = v; p0_in1 = a; p0_in2 = b; p0_twoc = tc;
        p0_op = 2'b00; p0_setflag = 3'b111; p0_lor = 1'b0; p0_arith = 1'b0;
    endtask

    task automatic set_p1(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic tc);
        p1_req_valid = v; p1_in1 = a; p1_in2 = b; p1_twoc = tc;
        p1_op = 2'b00; p1_setflag = 3'b111; p1_lor = 1'b0; p1_arith = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        set_p0(1'b0, 32'd0, 32'd0, 1'b0);
        set_p1(1'b0, 32'd0, 32'd0, 1'b0);
        p0_rsp_ready = 1'b1;
        p1_rsp_ready = 1'b1;
        #2;
        n_checks++; if ({p0_rsp_valid, p1_rsp_valid} !== 2'b00) $display("FAIL reset_rsp_valid got %b want 00", {p0_rsp_valid, p1_rsp_valid}); else n_pass++;
        n_checks++; if ({p0_result, p1_result} !== 64'd0) $display("FAIL reset_results got %h want 0", {p0_result, p1_result}); else n_pass++;
        step();
        rst_n = 1'b1;
        // Leave a p0 response pending, then reset mid-cycle.
        step();
        set_p0(1'b1, 32'd5, 32'd7, 1'b0);
        p0_rsp_ready = 1'b0;
        step();
        set_p0(1'b0, 32'd0, 32'd0, 1'b0);
        n_checks++; if (p0_rsp_valid !== 1'b1 || p0_result !== 32'd12) $display("FAIL pre_reset_pending got v=%b r=%h want v=1 r=0000000c", p0_rsp_valid, p0_result); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (p0_rsp_valid !== 1'b0) $display("FAIL async_reset_valid got %b want 0", p0_rsp_valid); else n_pass++;
        n_checks++; if (p0_result !== 32'd0 || p0_zero !== 1'b0) $display("FAIL async_reset_data got r=%h z=%b want 0", p0_result, p0_zero); else n_pass++;
        step();
        rst_n = 1'b1;
        p0_rsp_ready = 1'b1;
        set_p0(1'b1, 32'd1, 32'd1, 1'b0);
        set_p1(1'b1, 32'd10, 32'd20, 1'b0);
        #3;
        n_checks++; if ({p0_req_ready, p1_req_ready} !== 2'b10) $display("FAIL first_grant got %b want 10", {p0_req_ready, p1_req_ready}); else n_pass++;
        step();
        set_p0(1'b0, 32'd0, 32'd0, 1'b0);
        set_p1(1'b0, 32'd0, 32'd0, 1'b0);
        n_checks++; if (p0_rsp_valid !== 1'b1 || p0_result !== 32'd2 || p1_rsp_valid !== 1'b0) $display("FAIL first_grant_rsp got v0=%b r0=%h v1=%b want 1 2 0", p0_rsp_valid, p0_result, p1_rsp_valid); else n_pass++;
    endtask

    task automatic test_single_add;
        step();
        set_p0(1'b1, 32'h2A855ECD, 32'h9AA55ECD, 1'b0);
        #3;
        n_checks++; if (p0_req_ready !== 1'b1) $display("FAIL add_req_ready got %b want 1", p0_req_ready); else n_pass++;
        n_checks++; if (alu_in1 !== 32'h2A855ECD || alu_in2 !== 32'h9AA55ECD || alu_setflag !== 3'b111) $display("FAIL add_alu_mux got %h %h %b", alu_in1, alu_in2, alu_setflag); else n_pass++;
        step();
        set_p0(1'b0, 32'd0, 32'd0, 1'b0);
        n_checks++; if (p0_rsp_valid !== 1'b1 || p0_result !== 32'hC52ABD9A || p0_zero !== 1'b0) $display("FAIL add_rsp got v=%b r=%h z=%b want 1 c52abd9a 0", p0_rsp_valid, p0_result, p0_zero); else n_pass++;
        step();
        n_checks++; if (p0_rsp_valid !== 1'b0) $display("FAIL add_rsp_consumed got %b want 0", p0_rsp_valid); else n_pass++;
    endtask

    task automatic test_sub_zero;
        set_p1(1'b1, 32'h2A855ECD, 32'h2A855ECD, 1'b1);
        #3;
        n_checks++; if (p1_req_ready !== 1'b1 || alu_twoc !== 1'b1) $display("FAIL sub_req got rdy=%b twoc=%b want 1 1", p1_req_ready, alu_twoc); else n_pass++;
        step();
        set_p1(1'b0, 32'd0, 32'd0, 1'b0);
        n_checks++; if (p1_rsp_valid !== 1'b1 || p1_result !== 32'd0 || p1_zero !== 1'b1) $display("FAIL sub_rsp got v=%b r=%h z=%b want 1 0 1", p1_rsp_valid, p1_result, p1_zero); else n_pass++;
        step();
    endtask

    task automatic test_contention;
        logic g0;
        set_p0(1'b1, 32'd1, 32'd1, 1'b0);
        set_p1(1'b1, 32'd10, 32'd20, 1'b0);
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            g0 = (i % 2 == 0);
`else
            g0 = 1'b1;
`endif
            #3;
            n_checks++; if ({p0_req_ready, p1_req_ready} !== {g0, ~g0}) $display("FAIL contention_grant[%0d] got %b want %b", i, {p0_req_ready, p1_req_ready}, {g0, ~g0}); else n_pass++;
            n_checks++; if (alu_in1 !== (g0 ? 32'd1 : 32'd10)) $display("FAIL contention_mux[%0d] got %h want %h", i, alu_in1, g0 ? 32'd1 : 32'd10); else n_pass++;
            step();
            n_checks++; if (g0 ? (p0_result !== 32'd2) : (p1_result !== 32'd30)) $display("FAIL contention_rsp[%0d] got %h/%h", i, p0_result, p1_result); else n_pass++;
        end
        set_p0(1'b0, 32'd0, 32'd0, 1'b0);
        set_p1(1'b0, 32'd0, 32'd0, 1'b0);
        step();
    endtask

    task automatic test_backpressure;
        p0_rsp_ready = 1'b0;
        set_p0(1'b1, 32'd5, 32'd7, 1'b0);
        step();
        set_p0(1'b1, 32'd100, 32'd1, 1'b0);
        set_p1(1'b1, 32'd3, 32'd4, 1'b0);
        #3;
        n_checks++; if ({p0_req_ready, p1_req_ready} !== 2'b01) $display("FAIL bp_grant got %b want 01", {p0_req_ready, p1_req_ready}); else n_pass++;
        n_checks++; if (p0_rsp_valid !== 1'b1 || p0_result !== 32'd12) $display("FAIL bp_hold got v=%b r=%h want 1 0000000c", p0_rsp_valid, p0_result); else n_pass++;
        step();
        set_p1(1'b0, 32'd0, 32'd0, 1'b0);
        n_checks++; if (p0_result !== 32'd12 || p1_rsp_valid !== 1'b1 || p1_result !== 32'd7) $display("FAIL bp_stable got r0=%h v1=%b r1=%h want c 1 7", p0_result, p1_rsp_valid, p1_result); else n_pass++;
        p0_rsp_ready = 1'b1;
        #3;
        n_checks++; if (p0_req_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", p0_req_ready); else n_pass++;
        step();
        set_p0(1'b0, 32'd0, 32'd0, 1'b0);
        n_checks++; if (p0_rsp_valid !== 1'b1 || p0_result !== 32'd101) $display("FAIL bp_new_accept got v=%b r=%h want 1 00000065", p0_rsp_valid, p0_result); else n_pass++;
    endtask

    task automatic test_idle;
        step();
        step();
        #3;
        n_checks++; if ({alu_in1, alu_in2} !== 64'd0) $display("FAIL idle_operands got %h %h want 0", alu_in1, alu_in2); else n_pass++;
        n_checks++; if ({alu_twoc, alu_op, alu_setflag, alu_lor, alu_arith} !== 8'd0) $display("FAIL idle_controls got %b want 0", {alu_twoc, alu_op, alu_setflag, alu_lor, alu_arith}); else n_pass++;
        n_checks++; if ({p0_rsp_valid, p1_rsp_valid, p0_req_ready, p1_req_ready} !== 4'b0000) $display("FAIL idle_handshake got %b want 0000", {p0_rsp_valid, p1_rsp_valid, p0_req_ready, p1_req_ready}); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_sub_zero();
        test_contention();
        test_backpressure();
        test_idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
